raster_scan_counter: RTL and testbench

Parametrised 2-D raster address generator for sprite and screen memory traversal: it produces column/row coordinates and a linear memory address for a COLS×ROWS region, one pixel per step. It covers both the full-screen (160×120) and sprite (40×40) address counters, and optionally folds in a programmable step prescaler for slow animation timing. It sits between the game control FSM (start/abort/hold) and the sprite/screen ROM address and VGA plot logic.

---
 rtl/raster_scan_counter.sv | 191 +++++++++++++++++++
 tb/tb_raster_scan_counter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_scan_counter
//  Description : 2-D raster address generator. Walks a COLS x ROWS region one
//                pixel per step, emitting column/row coordinates and the
//                linear address y*COLS + x, built up incrementally with no
//                multiplier. Supports single-pass or continuous (looping)
//                scans, plus hold and abort controls.
//                Optional build macro SCAN_PRESCALE_EN adds a DIV-cycle step
//                prescaler for slow animation timing.
//  Revision    : 1.0  initial release
// ============================================================================
module raster_scan_counter #(
    parameter int COLS   = 40,
    parameter int ROWS   = 40,
    parameter int X_W    = 6,
    parameter int Y_W    = 6,
    parameter int ADDR_W = 11,
    parameter int DIV    = 12500000,
    parameter int DIV_W  = 26
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic              hold,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              lastPixel,
    output logic              done,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (COLS < 2 || ROWS < 2) begin : g_bad_dims
        $error("raster_scan_counter: COLS and ROWS must both be at least 2");
    end

    if (COLS > (2 ** X_W)) begin : g_bad_x_w
        $error("raster_scan_counter: X_W too narrow for COLS");
    end

    if (ROWS > (2 ** Y_W)) begin : g_bad_y_w
        $error("raster_scan_counter: Y_W too narrow for ROWS");
    end

    if ((COLS * ROWS) > (2 ** ADDR_W)) begin : g_bad_addr_w
        $error("raster_scan_counter: ADDR_W too narrow for COLS*ROWS");
    end

    if (DIV < 1 || (DIV - 1) >= (2 ** DIV_W)) begin : g_bad_div
        $error("raster_scan_counter: DIV must be >= 1 and fit in DIV_W bits");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [X_W-1:0]    c_x_last   = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]    c_y_last   = Y_W'(ROWS - 1);
    localparam logic [X_W-1:0]    c_x_one    = X_W'(1);
    localparam logic [Y_W-1:0]    c_y_one    = Y_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t              r_state;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_done;
    logic                r_loop;

    logic                w_tick;
    logic                w_valid;
    logic                w_x_end;
    logic                w_last;

    // ------------------------------------------------------------------------
    // Step timing: either every SCAN cycle or once per DIV unheld cycles
    // ------------------------------------------------------------------------
`ifdef SCAN_PRESCALE_EN
    localparam logic [DIV_W-1:0] c_pre_last = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] c_pre_one  = DIV_W'(1);

    logic [DIV_W-1:0] r_pre;

    assign w_tick = (r_pre == c_pre_last);

    // Prescaler: runs only while scanning and unheld, cleared outside SCAN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre <= '0;
        end else if (r_state != S_SCAN || abort) begin
            r_pre <= '0;
        end else if (!hold) begin
            r_pre <= w_tick ? '0 : (r_pre + c_pre_one);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Combinational step qualifiers
    // ------------------------------------------------------------------------
    assign w_valid = (r_state == S_SCAN) && w_tick && !hold;
    assign w_x_end = (r_x == c_x_last);
    assign w_last  = w_valid && w_x_end && (r_y == c_y_last);

    // ------------------------------------------------------------------------
    // Scan FSM with coordinate / address counters and done pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_loop  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Simultaneous abort vetoes the start request
                    if (start && !abort) begin
                        r_state <= S_SCAN;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_loop  <= loop;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        // Abort wins over a coincident last-pixel step: no done
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                    end else if (w_valid) begin
                        if (w_last) begin
                            r_x    <= '0;
                            r_y    <= '0;
                            r_addr <= '0;
                            r_done <= 1'b1;
                            if (!r_loop) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_addr <= r_addr + c_addr_one;
                            if (w_x_end) begin
                                r_x <= '0;
                                r_y <= r_y + c_y_one;
                            end else begin
                                r_x <= r_x + c_x_one;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign x         = r_x;
    assign y         = r_y;
    assign addr      = r_addr;
    assign done      = r_done;
    assign busy      = (r_state == S_SCAN);
    assign valid     = w_valid;
    assign lastPixel = w_last;

endmodule
`default_nettype wire

// File: tb/tb_raster_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raster_scan_counter
//  Description : Directed self-checking bench for raster_scan_counter on a
//                4 x 3 region. Prescaler sequence is used when the design is
//                built with SCAN_PRESCALE_EN (DIV = 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_raster_scan_counter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       abort;
    logic       loop;
    logic       hold;
    logic [1:0] x;
    logic [1:0] y;
    logic [3:0] addr;
    logic       valid;
    logic       lastPixel;
    logic       done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    raster_scan_counter #(
        .COLS   (4),
        .ROWS   (3),
        .X_W    (2),
        .Y_W    (2),
        .ADDR_W (4),
        .DIV    (3),
        .DIV_W  (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .loop      (loop),
        .hold      (hold),
        .x         (x),
        .y         (y),
        .addr      (addr),
        .valid     (valid),
        .lastPixel (lastPixel),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs be driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected outputs for an emitted pixel at linear address a on a 4x3 grid
    task automatic pixel(input int a);
        check("valid", 32'(valid), 1);
        check("x", 32'(x), a % 4);
        check("y", 32'(y), a / 4);
        check("addr", 32'(addr), a);
        check("lastPixel", 32'(lastPixel), (a == 11) ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        loop   = 1'b0;
        hold   = 1'b0;
        #2;
        // Reset values, applied with no clock edge yet
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_last", 32'(lastPixel), 0);
        step();
        step();
        resetn = 1'b1;
        settle();

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        settle();
        check("sa_busy", 32'(busy), 0);
        check("sa_valid", 32'(valid), 0);

`ifdef SCAN_PRESCALE_EN
        // Prescaled single pass: valid every 3rd cycle, lastPixel at cycle 36
        start = 1'b1;
        step();
        start = 1'b0;
        settle();
        for (int j = 1; j <= 36; j++) begin
            check("pre_busy", 32'(busy), 1);
            if (j % 3 == 0) begin
                pixel(j / 3 - 1);
            end else begin
                check("pre_valid", 32'(valid), 0);
            end
            step();
            settle();
        end
        check("pre_done", 32'(done), 1);
        check("pre_busy_end", 32'(busy), 0);
`else
        // Single pass, 12 consecutive pixels then done
        start = 1'b1;
        loop  = 1'b0;
        step();
        start = 1'b0;
        settle();
        check("a_busy", 32'(busy), 1);
        for (int i = 0; i < 12; i++) begin
            pixel(i);
            check("a_done", 32'(done), 0);
            step();
            settle();
        end
        check("a_done_end", 32'(done), 1);
        check("a_busy_end", 32'(busy), 0);
        check("a_valid_end", 32'(valid), 0);
        check("a_addr_end", 32'(addr), 0);

        // New start accepted in the done cycle; start during SCAN ignored
        start = 1'b1;
        step();
        start = 1'b0;
        settle();
        for (int i = 0; i < 12; i++) begin
            pixel(i);
            check("d_busy", 32'(busy), 1);
            if (i == 5) begin
                start = 1'b1;
                loop  = 1'b1;
            end
            step();
            start = 1'b0;
            loop  = 1'b0;
            settle();
        end
        check("d_done_end", 32'(done), 1);
        check("d_busy_end", 32'(busy), 0);
        step();
        settle();
        check("d_done_clear", 32'(done), 0);

        // Looping scan, wrap without gap, then abort on a last-pixel step
        start = 1'b1;
        loop  = 1'b1;
        step();
        start = 1'b0;
        loop  = 1'b0;
        settle();
        for (int i = 0; i < 24; i++) begin
            pixel(i % 12);
            check("b_busy", 32'(busy), 1);
            check("b_done", 32'(done), (i > 0 && i % 12 == 0) ? 1 : 0);
            if (i == 23) abort = 1'b1;
            step();
            abort = 1'b0;
            settle();
        end
        check("b_abort_busy", 32'(busy), 0);
        check("b_abort_done", 32'(done), 0);
        check("b_abort_addr", 32'(addr), 0);
        check("b_abort_valid", 32'(valid), 0);
        step();
        settle();
        check("b_abort_done2", 32'(done), 0);

        // Hold for 5 cycles at addr 6; still exactly 12 valids
        start = 1'b1;
        step();
        start = 1'b0;
        settle();
        n_valid = 0;
        for (int c = 0; c < 17; c++) begin
            hold = (c >= 6 && c < 11);
            settle();
            if (c >= 6 && c < 11) begin
                check("c_hold_valid", 32'(valid), 0);
                check("c_hold_addr", 32'(addr), 6);
                check("c_hold_last", 32'(lastPixel), 0);
            end else begin
                pixel((c < 6) ? c : c - 5);
            end
            check("c_done", 32'(done), 0);
            if (valid) n_valid++;
            step();
        end
        hold = 1'b0;
        settle();
        check("c_nvalid", 32'(n_valid), 12);
        check("c_done_end", 32'(done), 1);
        check("c_busy_end", 32'(busy), 0);

        // Asynchronous reset mid-frame at addr 7
        start = 1'b1;
        step();
        start = 1'b0;
        settle();
        for (int i = 0; i < 8; i++) begin
            pixel(i);
            if (i < 7) begin
                step();
                settle();
            end
        end
        resetn = 1'b0;
        settle();
        check("e_x", 32'(x), 0);
        check("e_y", 32'(y), 0);
        check("e_addr", 32'(addr), 0);
        check("e_busy", 32'(busy), 0);
        check("e_done", 32'(done), 0);
        check("e_valid", 32'(valid), 0);
        step();
        step();
        resetn = 1'b1;
        settle();
        check("e_busy_rel", 32'(busy), 0);
        check("e_done_rel", 32'(done), 0);
        step();
        settle();
        check("e_done_after", 32'(done), 0);
        check("e_valid_after", 32'(valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
